// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings, the
// fetch-buffer entry layout and small helpers.
package ifetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] IFU_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IFU_IDLE   = 2'd0,
    IFU_RUN    = 2'd1,
    IFU_HALTED = 2'd2
  } ifu_state_e;

  // One fetch-buffer entry: the PC travels with its instruction.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] value);
    return (value == '1) ? value : value + XLEN'(1);
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Parameterised synchronous FIFO with push/pop/flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally. A push on a
// full FIFO is accepted when a pop happens in the same cycle. Flush wins over
// push and pop. The head output reads zero while the FIFO is empty.
module ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Accepted push/pop and next pointer/count values.
  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    do_pop   = pop && !flush && !empty;
    do_push  = push && !flush && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage next-state: write the tail slot on an accepted push.
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_data;
  end

  // Pointer and count registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  // NOTE: the array is deliberately not reset; count_q alone decides which
  // entries are meaningful, so clearing the data would buy nothing.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Head entry, masked to zero when nothing is buffered.
  always_comb begin
    pop_data = empty ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage. Owns the PC, drives the instruction memory
// address every cycle, captures the same-cycle instruction into a PC-tagged
// fetch buffer and hands {pc, instr} to decode over valid/ready.
// Redirects flush the buffer and reload the PC; halt stops fetching until
// the next redirect.
// Optional build macro: IFETCH_PERF_CNT_EN adds saturating fetch, stall and
// flush counters.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = IFU_RESET_PC,
  parameter int          FIFO_DEPTH = 2,
  parameter int unsigned PC_STEP    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        halted,
  output logic        misalign_err
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam logic [XLEN-1:0] PC_INC = XLEN'(PC_STEP);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;

  logic            redirect_take;
  logic            do_pop;
  logic            fetch_en;
  logic            fifo_full, fifo_empty;
  fetch_entry_t    push_entry, head_entry;
  // Occupancy is exported by the FIFO for the decode skid buffer; the fetch
  // stage only needs full/empty.
  logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;

  // Fetch, pop and redirect qualification for this cycle.
  always_comb begin
    redirect_take = redirect_valid && (state_q != IFU_IDLE);
    do_pop        = out_valid && out_ready;
    fetch_en      = (state_q == IFU_RUN) && !halt_req && !redirect_take &&
                    (!fifo_full || do_pop);
    push_entry    = '{pc: pc_q, instr: imem_instr};
  end

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fetch_en),
    .push_data (push_entry),
    .pop       (do_pop),
    .flush     (redirect_take),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (unused_fifo_count)
  );

  // State, PC and misalign-pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IFU_IDLE;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  // Next state: IDLE lasts one cycle; redirect always lands in RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IFU_IDLE:   state_d = IFU_RUN;
      IFU_RUN:    if (!redirect_take && halt_req) state_d = IFU_HALTED;
      IFU_HALTED: if (redirect_take) state_d = IFU_RUN;
      default:    state_d = IFU_IDLE;
    endcase
  end

  // Next PC and misalignment flag; redirect beats sequential fetch.
  always_comb begin
    pc_d       = pc_q;
    misalign_d = redirect_take && (redirect_pc[1:0] != 2'b00);
    if (redirect_take) begin
      pc_d = align_word(redirect_pc);
    end else if (fetch_en) begin
      pc_d = pc_q + PC_INC;
    end
  end

  // Outputs: memory address, decode head entry and status.
  always_comb begin
    imem_addr    = pc_q;
    out_valid    = !fifo_empty;
    out_pc       = head_entry.pc;
    out_instr    = head_entry.instr;
    halted       = (state_q == IFU_HALTED);
    misalign_err = misalign_q;
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [XLEN-1:0] perf_fetch_q, perf_fetch_d;
  logic [XLEN-1:0] perf_stall_q, perf_stall_d;
  logic [XLEN-1:0] perf_flush_q, perf_flush_d;
  logic            stall_evt;

  // Counter increments: fetches, RUN cycles lost to a full buffer, redirects.
  always_comb begin
    stall_evt    = (state_q == IFU_RUN) && !halt_req && !redirect_take &&
                   fifo_full && !do_pop;
    perf_fetch_d = fetch_en      ? sat_inc(perf_fetch_q) : perf_fetch_q;
    perf_stall_d = stall_evt     ? sat_inc(perf_stall_q) : perf_stall_q;
    perf_flush_d = redirect_take ? sat_inc(perf_flush_q) : perf_flush_q;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit (FIFO_DEPTH=2, PC_STEP=4, RESET_PC=0).
// Stimulus pushes the expected {pc, instr} for every entry decode should
// accept; a monitor pops and compares on each handshake. Direct checks
// cover reset, latency, stalls, redirect, misalignment, wrap and halt.
module tb_ifetch_unit;

  localparam logic [31:0] K = 32'h0010_0531;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        halted;
  logic        misalign_err;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  logic xor_mode;
  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  ifetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .halted         (halted),
    .misalign_err   (misalign_err)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: constant word first, then an address-dependent word so a
  // wrong PC tag or wrong slot shows up in the instruction too.
  always_comb imem_instr = xor_mode ? (imem_addr ^ K) : K;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    sb_q.push_back(e);
  endtask

  // Monitor: compare every accepted head entry against the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got pc %h want no entry", out_pc);
        end else begin
          e = sb_q.pop_front();
          check("sb_pc", out_pc, e.pc);
          check("sb_instr", out_instr, e.instr);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    halt_req       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    xor_mode       = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);

    // Streaming from reset: pc 0,4,8,12 back to back.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) expect_entry(32'(i * 4), K);
    rst_n = 1'b1;
    tick();
    check("idle_no_valid", 32'(out_valid), 32'd0);
    check("idle_addr", imem_addr, 32'h0);
    tick();
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_pc", out_pc, 32'h0);
    repeat (4) tick();
    out_ready = 1'b0;
    check("stream_drained", sb_q.size(), 32'd0);

    // Mid-run reset discards buffered entries.
    rst_n    = 1'b0;
    xor_mode = 1'b1;
    tick();
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_addr", imem_addr, 32'h0);
    tick();
    rst_n = 1'b1;

    // Backpressure: buffer fills with pc 0,4 and the PC parks at 8.
    repeat (4) tick();
    check("stall_pc_stable", out_pc, 32'h0);
    tick();
    check("stall_addr", imem_addr, 32'h8);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_pc", out_pc, 32'h0);
    check("stall_instr", out_instr, K);
    expect_entry(32'h0, K);
    expect_entry(32'h4, 32'h4 ^ K);
    expect_entry(32'h8, 32'h8 ^ K);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    check("stall_drained", sb_q.size(), 32'd0);

    // Redirect with a full buffer flushes it.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check("redir_flush_valid", 32'(out_valid), 32'd0);
    check("redir_addr", imem_addr, 32'h40);
    check("redir_no_misalign", 32'(misalign_err), 32'd0);
    tick();
    expect_entry(32'h40, 32'h40 ^ K);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Misaligned redirect target: one-cycle pulse, fetch at aligned address.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    tick();
    redirect_valid = 1'b0;
    check("misalign_pulse", 32'(misalign_err), 32'd1);
    check("misalign_addr", imem_addr, 32'h40);
    check("misalign_flush", 32'(out_valid), 32'd0);
    tick();
    check("misalign_clear", 32'(misalign_err), 32'd0);
    check("misalign_valid", 32'(out_valid), 32'd1);
    check("misalign_pc", out_pc, 32'h40);
    expect_entry(32'h40, 32'h40 ^ K);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // PC wrap from the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    check("wrap_start", imem_addr, 32'hFFFF_FFF8);
    tick();
    check("wrap_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_zero", imem_addr, 32'h0);
    expect_entry(32'hFFFF_FFF8, 32'hFFFF_FFF8 ^ K);
    expect_entry(32'hFFFF_FFFC, 32'hFFFF_FFFC ^ K);
    expect_entry(32'h0, K);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    check("wrap_drained", sb_q.size(), 32'd0);

    // Halt: stays halted after halt_req drops, PC frozen, buffer drains.
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("halt_set", 32'(halted), 32'd1);
    check("halt_addr", imem_addr, 32'hC);
    expect_entry(32'h4, 32'h4 ^ K);
    expect_entry(32'h8, 32'h8 ^ K);
    out_ready = 1'b1;
    tick();
    check("halt_hold", 32'(halted), 32'd1);
    tick();
    check("halt_empty", 32'(out_valid), 32'd0);
    check("halt_pc_frozen", imem_addr, 32'hC);
    tick();
    check("halt_still", 32'(halted), 32'd1);
    check("halt_drained", sb_q.size(), 32'd0);

    // Redirect resumes fetching.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("resume_halted", 32'(halted), 32'd0);
    check("resume_addr", imem_addr, 32'h100);
    expect_entry(32'h100, 32'h100 ^ K);
    tick();
    check("resume_next_addr", imem_addr, 32'h104);
    tick();
    out_ready = 1'b0;
    tick();
    tick();
    check("final_drained", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
